// File: rtl/bcd_countdown.sv
// Loadable DIGITS-wide BCD down-counter with start/hold control, terminal-count pulse and optional auto-reload.
// Latency: load/tick_en sampled at edge k show in cnt right after edge k; busy/done registered; zero is combinational from cnt.
// No backpressure: inputs are strobes/levels taken every cycle; load > start > hold > tick_en.
module bcd_countdown #(
  parameter int DIGITS = 2,
  parameter int RELOAD = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  start,
  input  logic                  hold,
  input  logic                  tick_en,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  zero
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] cnt_q, cnt_d;
  logic [4*DIGITS-1:0] rld_q, rld_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic [4*DIGITS-1:0] dec_val;
  logic [4*DIGITS-1:0] clamp_val;

  // Force every nibble into 0..9 so the counter never holds a non-BCD digit.
  function automatic logic [4*DIGITS-1:0] clamp_bcd(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    end
    return r;
  endfunction

  // One BCD step down; the borrow ripples through every digit in one cycle.
  function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
    logic [4*DIGITS-1:0] r;
    logic                borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Datapath helpers shared by the next-state logic.
  always_comb begin
    dec_val   = bcd_dec(cnt_q);
    clamp_val = clamp_bcd(load_val);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rld_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rld_q   <= rld_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state and next-count logic in priority order load > start > hold > tick_en.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rld_d   = rld_q;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = clamp_val;
      rld_d   = clamp_val;
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && (cnt_q != '0)) begin
            state_d = hold ? ST_HOLD : ST_RUN;
          end
        end
        ST_RUN: begin
          if (cnt_q == '0) begin
            // Only reachable in reload mode: the zero cycle is spent reloading.
            if (rld_q == '0) begin
              state_d = ST_DONE;
            end else begin
              cnt_d   = rld_q;
              state_d = hold ? ST_HOLD : ST_RUN;
            end
          end else if (hold) begin
            state_d = ST_HOLD;
          end else if (tick_en) begin
            cnt_d = dec_val;
            if (dec_val == '0) begin
              done_d = 1'b1;
              if (RELOAD == 0) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_HOLD: begin
          if (!hold) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs: busy is registered from the next state; zero decodes the count.
  always_comb begin
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    cnt    = cnt_q;
    busy   = busy_q;
    done   = done_q;
    zero   = (cnt_q == '0);
  end

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed bench for bcd_countdown: one stop-mode and one reload-mode instance share stimulus.
// Inputs change 1 ns after the rising edge; outputs are checked in the same window.
// Each comparison is an immediate assertion that counts and reports its own failure.
module tb_bcd_countdown;

  logic       clk;
  logic       rstn;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       hold;
  logic       tick_en;
  logic [7:0] cnt0, cnt1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic       zero0, zero1;

  int checks   = 0;
  int failures = 0;

  bcd_countdown #(.DIGITS(2), .RELOAD(0)) dut0 (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start),
    .hold(hold), .tick_en(tick_en), .cnt(cnt0), .busy(busy0), .done(done0), .zero(zero0)
  );

  bcd_countdown #(.DIGITS(2), .RELOAD(1)) dut1 (
    .clk(clk), .rstn(rstn), .load(load), .load_val(load_val), .start(start),
    .hold(hold), .tick_en(tick_en), .cnt(cnt1), .busy(busy1), .done(done1), .zero(zero1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] rl_cnt  [8] = '{8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
  logic       rl_done [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    rstn = 1'b0; load = 1'b0; load_val = 8'h00; start = 1'b0; hold = 1'b0; tick_en = 1'b0;

    // Reset state
    #12;
    chk("rst_cnt",  32'(cnt0), 32'h00);
    chk("rst_busy", 32'(busy0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_zero", 32'(zero0), 32'h1);
    chk("rst_cnt1", 32'(cnt1), 32'h00);
    rstn = 1'b1;
    cyc();

    // Preset and clamping
    load = 1'b1; load_val = 8'h25; cyc(); load = 1'b0;
    chk("load25_cnt",  32'(cnt0), 32'h25);
    chk("load25_busy", 32'(busy0), 32'h0);
    chk("load25_zero", 32'(zero0), 32'h0);
    load = 1'b1; load_val = 8'hAF; cyc(); load = 1'b0;
    chk("clampAF_cnt", 32'(cnt0), 32'h99);

    // Borrow ripple down to terminal count
    load = 1'b1; load_val = 8'h20; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_busy", 32'(busy0), 32'h1);
    chk("start_cnt",  32'(cnt0), 32'h20);
    tick_en = 1'b1; cyc();
    chk("borrow_19", 32'(cnt0), 32'h19);
    for (int i = 0; i < 9; i++) cyc();
    chk("reach_10", 32'(cnt0), 32'h10);
    cyc();
    chk("borrow_09", 32'(cnt0), 32'h09);
    chk("run_done_lo", 32'(done0), 32'h0);
    for (int i = 0; i < 8; i++) cyc();
    chk("reach_01", 32'(cnt0), 32'h01);
    cyc();
    chk("tc_cnt",  32'(cnt0), 32'h00);
    chk("tc_done", 32'(done0), 32'h1);
    chk("tc_busy", 32'(busy0), 32'h0);
    chk("tc_zero", 32'(zero0), 32'h1);
    cyc();
    chk("tc_done_fall", 32'(done0), 32'h0);
    chk("tc_cnt_stay",  32'(cnt0), 32'h00);
    tick_en = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("start_at_zero_busy", 32'(busy0), 32'h0);

    // Hold freezes the count, release cycle ignores tick_en
    load = 1'b1; load_val = 8'h05; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    tick_en = 1'b1; cyc(); cyc();
    chk("hold_pre_03", 32'(cnt0), 32'h03);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("hold_frozen", 32'(cnt0), 32'h03);
    end
    chk("hold_busy", 32'(busy0), 32'h1);
    hold = 1'b0; cyc();
    chk("hold_release", 32'(cnt0), 32'h03);
    cyc();
    chk("hold_resume_02", 32'(cnt0), 32'h02);
    tick_en = 1'b0;

    // Reload mode: 3,2,1,0,3,... with done at each zero
    load = 1'b1; load_val = 8'h03; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    chk("rl_start_cnt", 32'(cnt1), 32'h03);
    tick_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rl_cnt",  32'(cnt1), 32'(rl_cnt[i]));
      chk("rl_done", 32'(done1), 32'(rl_done[i]));
      chk("rl_busy", 32'(busy1), 32'h1);
    end
    chk("stop_mode_idle_busy", 32'(busy0), 32'h0);
    tick_en = 1'b0;

    // load + start together: load wins, stays idle
    load = 1'b1; start = 1'b1; load_val = 8'h42; cyc(); load = 1'b0; start = 1'b0;
    chk("ldst_busy", 32'(busy0), 32'h0);
    chk("ldst_cnt",  32'(cnt0), 32'h42);
    cyc();
    chk("ldst_still_idle", 32'(busy0), 32'h0);
    // start during RUN does not restart
    start = 1'b1; cyc(); start = 1'b0;
    tick_en = 1'b1; cyc();
    chk("run_41", 32'(cnt0), 32'h41);
    start = 1'b1; cyc();
    chk("restart_ignored_40", 32'(cnt0), 32'h40);
    cyc();
    chk("restart_ignored_39", 32'(cnt0), 32'h39);
    start = 1'b0; tick_en = 1'b0;

    // Async reset mid-count
    load = 1'b1; load_val = 8'h15; cyc(); load = 1'b0;
    start = 1'b1; cyc(); start = 1'b0;
    tick_en = 1'b1; cyc();
    chk("ar_pre_14", 32'(cnt0), 32'h14);
    #2 rstn = 1'b0;
    #1;
    chk("ar_cnt",  32'(cnt0), 32'h00);
    chk("ar_busy", 32'(busy0), 32'h0);
    chk("ar_done", 32'(done0), 32'h0);
    chk("ar_zero", 32'(zero0), 32'h1);
    cyc();
    chk("ar_hold_cnt",  32'(cnt0), 32'h00);
    chk("ar_hold_done", 32'(done0), 32'h0);
    rstn = 1'b1; tick_en = 1'b0;
    cyc();
    chk("ar_after_busy", 32'(busy0), 32'h0);
    chk("ar_after_cnt",  32'(cnt0), 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
